// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the arbiter, the two cache requesters and the memory port.
// master: arbiter side (drives grants, beat status and the memory request).
// slave:  environment side (caches and memory model).
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4
);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // icache requester
    logic                  i_req;
    logic                  i_we;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic                  i_done;

    // dcache requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic                  d_done;

    // shared return path
    logic [DATA_WIDTH-1:0] rdata;
    logic [CW-1:0]         beat_idx;

    // memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        input  i_req, i_we, i_addr, i_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_gnt, i_rvalid, i_done,
        output d_gnt, d_rvalid, d_done,
        output rdata, beat_idx,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_we, i_addr, i_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_gnt, i_rvalid, i_done,
        input  d_gnt, d_rvalid, d_done,
        input  rdata, beat_idx,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-way burst arbiter sharing one memory port between icache and dcache.
// Grants whole aligned bursts of BURST_LEN words, generates beat addresses,
// and alternates ownership on contention. One IDLE cycle separates bursts.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input logic             clk,
    input logic             rst_n,
    mem_bus_arbiter_if.master bus
);
    localparam int CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFFW = $clog2(BURST_LEN) + 2;
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFW;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t                state, state_nx;
    logic                  last_d;      // 1: dcache held the bus last
    logic [ADDR_WIDTH-1:0] base;
    logic                  we_q;
    logic [CW-1:0]         beat_cnt;
    logic                  grant_i, grant_d;
    logic                  last_beat;

    assign last_beat = (beat_cnt == LAST_BEAT);
    assign bus.rdata = bus.mem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Arbitration, next state and bus outputs
    always_comb begin
        state_nx      = state;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        bus.i_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_done    = 1'b0;
        bus.beat_idx  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                // tie goes to whoever did not own the previous burst
                if (bus.i_req && bus.d_req) begin
                    grant_i = last_d;
                    grant_d = ~last_d;
                end else begin
                    grant_i = bus.i_req;
                    grant_d = bus.d_req;
                end
                if (grant_i)      state_nx = BUSY_I;
                else if (grant_d) state_nx = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                // OR instead of add: offset never carries out of the line
                bus.mem_addr  = base | (ADDR_WIDTH'(beat_cnt) << 2);
                bus.beat_idx  = beat_cnt;
                if (state == BUSY_I) begin
                    bus.i_gnt     = 1'b1;
                    bus.i_rvalid  = bus.mem_ready & ~we_q;
                    bus.i_done    = bus.mem_ready & last_beat;
                    bus.mem_wdata = bus.i_wdata;
                end else begin
                    bus.d_gnt     = 1'b1;
                    bus.d_rvalid  = bus.mem_ready & ~we_q;
                    bus.d_done    = bus.mem_ready & last_beat;
                    bus.mem_wdata = bus.d_wdata;
                end
                if (bus.mem_ready && last_beat) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Burst context: latched on grant, beat counter advanced per accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d   <= 1'b0;
            base     <= '0;
            we_q     <= 1'b0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i || grant_d) begin
                base     <= (grant_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
                we_q     <= grant_d ? bus.d_we : bus.i_we;
                beat_cnt <= '0;
            end
        end else if (bus.mem_ready) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat) last_d <= (state == BUSY_D);
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (BURST_LEN=4, 32-bit bus).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mem_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(4)) bus ();

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy[6] = '{1, 0, 0, 1, 1, 1};
        int eb[6]  = '{0, 1, 1, 1, 2, 3};

        rst_n = 1'b0;
        bus.i_req = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        step(); step(); step();

        // reset state, mem_ready in IDLE ignored, rdata follows mem_rdata
        bus.mem_ready = 1; bus.mem_rdata = 32'hABCD_0001;
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_i_gnt", bus.i_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_beat_idx", bus.beat_idx, 0);
        chk("rst_done", {bus.i_done, bus.d_done, bus.i_rvalid, bus.d_rvalid}, 0);
        chk("rst_rdata", bus.rdata, 32'hABCD_0001);
        rst_n = 1'b1;
        step();
        chk("idle_ready_ignored", bus.mem_req, 0);

        // simultaneous requests from reset: dcache first, then icache
        bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h44; bus.d_addr = 32'h84;
        #1;
        chk("tie_idle", bus.mem_req, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.mem_rdata = 32'h5000 + k;
            #1;
            chk("tie_d_gnt", {bus.d_gnt, bus.i_gnt}, 2'b10);
            chk("tie_d_addr", bus.mem_addr, 32'h80 + 4 * k);
            chk("tie_d_idx", bus.beat_idx, k);
            chk("tie_d_rvalid", {bus.d_rvalid, bus.i_rvalid}, 2'b10);
            chk("tie_rdata", bus.rdata, 32'h5000 + k);
            chk("tie_d_done", {bus.d_done, bus.i_done}, {(k == 3), 1'b0});
            step();
        end
        bus.d_req = 0;
        #1;
        chk("tie_turnaround", {bus.mem_req, bus.i_gnt, bus.d_gnt}, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("tie_i_gnt", {bus.d_gnt, bus.i_gnt}, 2'b01);
            chk("tie_i_addr", bus.mem_addr, 32'h40 + 4 * k);
            chk("tie_i_done", {bus.i_rvalid, bus.i_done}, {1'b1, (k == 3)});
            step();
        end
        bus.i_req = 0;
        #1;
        chk("tie_end_idle", bus.mem_req, 0);
        step();

        // single icache read at 0x104
        bus.i_req = 1; bus.i_addr = 32'h104;
        #1;
        chk("ird_idle", bus.i_gnt, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("ird_gnt", {bus.mem_req, bus.i_gnt, bus.mem_we}, 3'b110);
            chk("ird_addr", bus.mem_addr, 32'h100 + 4 * k);
            chk("ird_rvalid_done", {bus.i_rvalid, bus.i_done, bus.d_done}, {1'b1, (k == 3), 1'b0});
            step();
        end
        bus.i_req = 0;
        #1;
        chk("ird_n5_idle", {bus.mem_req, bus.i_gnt}, 0);
        step();

        // dcache write-back with stalls; addr/we changes after grant ignored
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000;
        #1;
        step();
        for (int c = 0; c < 6; c++) begin
            bus.mem_ready = rdy[c][0];
            bus.d_wdata   = 32'hD000_0000 + eb[c];
            bus.d_addr    = 32'h3000;
            bus.d_we      = 0;
            #1;
            chk("wr_wdata", bus.mem_wdata, 32'hD000_0000 + eb[c]);
            chk("wr_we", {bus.mem_req, bus.mem_we, bus.d_gnt}, 3'b111);
            chk("wr_addr", bus.mem_addr, 32'h2000 + 4 * eb[c]);
            chk("wr_idx", bus.beat_idx, eb[c]);
            chk("wr_done", {bus.d_rvalid, bus.d_done}, {1'b0, (c == 5)});
            step();
        end
        bus.d_req = 0; bus.mem_ready = 1;
        #1;
        chk("wr_end_idle", bus.mem_req, 0);
        step();

        // icache drops req mid-burst; dcache pending is served next
        bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h300; bus.d_addr = 32'h500;
        #1;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.i_req = 0;
            #1;
            chk("drop_i_gnt", {bus.i_gnt, bus.d_gnt}, 2'b10);
            chk("drop_i_addr", bus.mem_addr, 32'h300 + 4 * k);
            chk("drop_i_done", {bus.i_rvalid, bus.i_done}, {1'b1, (k == 3)});
            step();
        end
        #1;
        chk("drop_turnaround", {bus.mem_req, bus.d_gnt}, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("drop_d_addr", {bus.d_gnt, bus.mem_addr}, {1'b1, 32'h500 + 4 * k});
            chk("drop_d_done", bus.d_done, (k == 3));
            step();
        end
        bus.d_req = 0;
        #1;
        step();

        // reset at beat 2 of a dcache read; tie after release goes to dcache
        bus.d_req = 1; bus.d_addr = 32'h600;
        #1;
        step();
        step();
        step();
        #1;
        chk("rstmid_beat2", {bus.d_gnt, bus.beat_idx}, {1'b1, 2'd2});
        rst_n = 0;
        step();
        chk("rstmid_after", {bus.mem_req, bus.d_gnt, bus.d_done, bus.beat_idx}, 0);
        rst_n = 1; bus.i_req = 1; bus.i_addr = 32'h700;
        #1;
        chk("rstmid_idle", bus.mem_req, 0);
        step();
        chk("rstmid_tie", {bus.d_gnt, bus.i_gnt}, 2'b10);
        chk("rstmid_addr", bus.mem_addr, 32'h600);
        bus.i_req = 0; bus.d_req = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port between the instruction cache and the data cache so both can run line refills and write-backs over one bus. Sits below `icache` and `dcache`, outside the pipeline control logic. It grants whole bursts of `BURST_LEN` words, generates the beat addresses itself, and alternates grants when both caches contend.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width, in bits.
- `ADDR_WIDTH`, 32: byte address width.
- `BURST_LEN`, 4: beats per burst. Must be a power of two, ≥1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `i_req` in 1: icache burst request. Held high until `i_done`.
- `i_we` in 1: icache write flag. Always 0 in practice; still honoured.
- `i_addr` in `ADDR_WIDTH`: icache burst address.
- `i_wdata` in `DATA_WIDTH`: icache write data for the beat given by `beat_idx`.
- `i_gnt` out 1: icache owns the bus.
- `i_rvalid` out 1: read beat valid for icache.
- `i_done` out 1: last beat of the icache burst is complete.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_done`: same as the icache ports, for the dcache.
- `rdata` out `DATA_WIDTH`: read data, shared by both requesters. Equals `mem_rdata`.
- `beat_idx` out `log2(BURST_LEN)` (min 1): current beat number.
- `mem_req` out 1: memory transaction valid.
- `mem_we` out 1: memory write.
- `mem_addr` out `ADDR_WIDTH`: beat address.
- `mem_wdata` out `DATA_WIDTH`: beat write data.
- `mem_rdata` in `DATA_WIDTH`: memory read data.
- `mem_ready` in 1: beat accepted. Read data is valid in the same cycle.

## Operation
- FSM states:
  - `IDLE`: no owner. `mem_req`=0. Samples `i_req` and `d_req`.
  - `BUSY_I`: icache owns the bus. `i_gnt`=1.
  - `BUSY_D`: dcache owns the bus. `d_gnt`=1.
- Arbitration (IDLE only):
  - One requester active: that requester is granted.
  - Both active: the requester not granted last time wins.
  - `last_grant` resets to icache, so the dcache wins the first tie.
- On grant, the arbiter latches:
  - base address = requester address with the low `log2(BURST_LEN)+2` bits cleared;
  - `we`;
  - owner.
  - `beat_cnt` is cleared to 0.
- Beat addressing: `mem_addr` = base + (`beat_cnt` × 4). No carry beyond the aligned line.
- In BUSY states:
  - `mem_req` = 1.
  - `mem_we` = latched `we`.
  - `mem_wdata` = owner's `wdata`, combinationally.
  - `beat_idx` = `beat_cnt`.
- A beat completes on `mem_req & mem_ready`. On completion, `beat_cnt` increments.
- On a read beat, the owner's `rvalid` = `mem_ready & ~we`. Not registered.
- Owner's `done` = `mem_ready` on beat `BURST_LEN-1`. Combinational, one-cycle pulse.
- Next state after the done beat is IDLE. At that transition `last_grant` ← owner.
- The requester must drop `req` in the cycle after `done`. A `req` still high in that IDLE cycle is a new request.
- A requester that drops `req` mid-burst does not abort the burst. The burst completes, and `rvalid`/`done` still pulse.
- `*_addr` and `*_we` changes after grant are ignored until the next IDLE.
- The non-owner's `gnt`, `rvalid` and `done` are always 0.

## Timing
- Reset values: state IDLE, `last_grant`=icache, `beat_cnt`=0. All outputs 0, except `rdata`, which follows `mem_rdata`.
- Grant latency: `req` seen high in IDLE at cycle N → `gnt` and `mem_req` high at N+1.
- Beat throughput: one beat per cycle while `mem_ready`=1. Each `mem_ready`=0 cycle stalls the burst with address and data held.
- Minimum burst occupancy: `BURST_LEN` cycles, plus one IDLE turnaround cycle before any new grant. Back-to-back grants never occur.
- `BURST_LEN`=1: the first beat is also the done beat.
- `rst_n` low in any state:
  - next cycle is IDLE with `mem_req`=0;
  - any in-flight burst is dropped;
  - no `done` is issued.
- `mem_ready` while in IDLE is ignored.

## Test plan
- **Single icache read:** `i_req`, `i_addr`=0x104, memory ready every cycle.
  - `mem_addr` = 0x100, 0x104, 0x108, 0x10C on cycles N+1..N+4.
  - `i_rvalid` high on all four beats; `i_done` on N+4; IDLE on N+5.
- **Simultaneous requests from reset:** both requests rise together, each held until its own done.
  - dcache is granted first.
  - icache is granted after the one-cycle IDLE that follows `d_done`.
- **Dcache write-back with stalls:** `d_we`=1, `d_addr`=0x2000, `mem_ready` pattern 1,0,0,1,1,1.
  - `mem_wdata` tracks `d_wdata` for `beat_idx` 0..3.
  - Address is held during the stalls.
  - `d_done` on the 6th BUSY cycle.
- **Request dropped mid-burst:** icache drops `i_req` after beat 1.
  - Beats 2 and 3 are still issued; `i_done` still pulses.
  - `d_req`, pending throughout, is granted after the IDLE cycle.
- **Reset mid-burst:** `rst_n`=0 at beat 2 of a dcache read.
  - Next cycle: `mem_req`=0 and `d_gnt`=0, with no `d_done`.
  - After release, a tie grants dcache first again (`last_grant` was reset).
